shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_pkg.sv | 15 +
 rtl/shift_reg_core.sv | 41 ++++
 rtl/shift_seq_ctrl.sv | 107 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and default sizing for the shift sequencer and its datapath.
package shift_seq_pkg;

    // Default shift register width and shift-count field width.
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    // Sequencer states: waiting for start, shifting, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_seq_pkg

// File: rtl/shift_reg_core.sv
// Shift register datapath: parallel load, one left shift per enabled edge,
// synchronous clear. The bit entering at the LSB comes from the fill input,
// so the controller decides between logical shift and rotate.
module shift_reg_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic             fill,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    // Register update: clear beats load, load beats shift, otherwise hold.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would let q feed its own update in-cycle.
    // NOTE: q is a handful of flops, not a memory array, so it is cheap and
    // correct to reset it; reset makes q/sout defined before the first load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            sout <= 1'b0;
        end else if (clear) begin
            q    <= '0;
            sout <= 1'b0;
        end else if (load) begin
            q    <= din;
            sout <= 1'b0;
        end else if (shift) begin
            sout <= q[WIDTH-1];
            q    <= {q[WIDTH-2:0], fill};
        end
    end

endmodule : shift_reg_core

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: loads a word on start, performs n_shift left shifts, then
// pulses done for one cycle. clr aborts from any state without a done pulse.
// Build option: define SHIFT_SEQ_ROTATE_EN to rotate (MSB re-enters at LSB)
// instead of shifting in zeros; ports, timing and sout are unaffected.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] n_shift,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             load;
    logic             shift;
    logic             clear;
    logic             fill;

    // State and remaining-shift counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state, counter and datapath-control decode; clr overrides all.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        if (clr) begin
            next_state = IDLE;
            next_cnt   = '0;
            clear      = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        load       = 1'b1;
                        next_cnt   = n_shift;
                        next_state = (n_shift == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    shift    = 1'b1;
                    next_cnt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Status is decoded straight from the registered state: glitch-free.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Bit entering the LSB on each shift.
`ifdef SHIFT_SEQ_ROTATE_EN
    assign fill = q[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .clear (clear),
        .fill  (fill),
        .din   (din),
        .q     (q),
        .sout  (sout)
    );

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl (WIDTH=4, CNT_W=3). Expected values
// come from closed-form shift/rotate arithmetic on the loaded word.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [CNT_W-1:0] n_shift = '0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .din     (din),
        .n_shift (n_shift),
        .clr     (clr),
        .q       (q),
        .sout    (sout),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Register contents after k shifts of word d.
    function automatic logic [WIDTH-1:0] model_q(input logic [WIDTH-1:0] d, input int k);
        int r;
`ifdef SHIFT_SEQ_ROTATE_EN
        int s;
        s = k % WIDTH;
        r = (int'(d) << s) | (int'(d) >> (WIDTH - s));
`else
        r = (k >= WIDTH) ? 0 : (int'(d) << k);
`endif
        return r[WIDTH-1:0];
    endfunction

    // Last bit pushed out of the MSB after k shifts of word d (0 before any).
    function automatic logic model_sout(input logic [WIDTH-1:0] d, input int k);
        if (k == 0) return 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
        return d[(WIDTH - (k % WIDTH)) % WIDTH];
`else
        if (k > WIDTH) return 1'b0;
        return d[WIDTH-k];
`endif
    endfunction

    // One full start..done sequence with per-cycle checks. With probe set,
    // start is re-pulsed (din=1111, n=1) during SHIFT and during DONE.
    task automatic run_seq(input string name, input logic [WIDTH-1:0] d,
                           input logic [CNT_W-1:0] n, input bit probe);
        int cyc;
        @(negedge clk);
        din = d; n_shift = n; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            n_checks++;
            if (q !== model_q(d, cyc) || sout !== model_sout(d, cyc) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s shift%0d: q=%b sout=%b done=%b, want q=%b sout=%b done=0",
                         name, cyc, q, sout, done, model_q(d, cyc), model_sout(d, cyc));
            end
            if (probe && cyc == 0) begin
                start = 1'b1; din = 4'b1111; n_shift = 3'd1;
            end
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (cyc !== int'(n)) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, want %0d", name, cyc, n);
        end
        n_checks++;
        if (done !== 1'b1 || q !== model_q(d, n) || sout !== model_sout(d, n)) begin
            n_fail++;
            $display("FAIL %s done_cycle: done=%b q=%b sout=%b, want done=1 q=%b sout=%b",
                     name, done, q, sout, model_q(d, n), model_sout(d, n));
        end
        if (probe) begin
            start = 1'b1; din = 4'b1111; n_shift = 3'd1;
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== model_q(d, n) || sout !== model_sout(d, n)) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b busy=%b q=%b sout=%b, want 0 0 %b %b",
                     name, done, busy, q, sout, model_q(d, n), model_sout(d, n));
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== '0 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: q=%b sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_seq("basic", 4'b1011, 3'd2, 1'b0);
`ifndef SHIFT_SEQ_ROTATE_EN
        n_checks++;
        if (q !== 4'b1100) begin
            n_fail++;
            $display("FAIL basic_q: got %b, want 1100", q);
        end
`endif
    endtask

    task automatic test_zero_shift();
        run_seq("zero", 4'b0110, 3'd0, 1'b0);
        n_checks++;
        if (q !== 4'b0110) begin
            n_fail++;
            $display("FAIL zero_q: got %b, want 0110", q);
        end
    endtask

    task automatic test_ignore_start();
        run_seq("ignore_start", 4'b1001, 3'd3, 1'b1);
    endtask

    task automatic test_long_shift();
        run_seq("long", 4'b1011, 3'd5, 1'b0);
        n_checks++;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (q !== 4'b0111) begin
            n_fail++;
            $display("FAIL long_q: got %b, want 0111", q);
        end
`else
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL long_q: got %b, want 0000", q);
        end
`endif
        run_seq("max", 4'b1110, 3'd7, 1'b0);
    endtask

    task automatic test_clr();
        @(negedge clk);
        din = 4'b0111; n_shift = 3'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (q !== '0 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_abort: q=%b sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL clr_quiet%0d: done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
        run_seq("preload", 4'b1010, 3'd0, 1'b0);
        @(negedge clk);
        clr = 1'b1; start = 1'b1; din = 4'b1111; n_shift = 3'd2;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        n_checks++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_priority: q=%b busy=%b done=%b, want 0000 0 0", q, busy, done);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        @(negedge clk);
        din = 4'b1101; n_shift = 3'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== '0 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: q=%b sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: done=%b busy=%b, want 0 0", done, busy);
        end
        rst_n = 1'b1;
        din = 4'b0011; n_shift = 3'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || q !== 4'b0011) begin
            n_fail++;
            $display("FAIL first_start: busy=%b q=%b, want 1 0011", busy, q);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 2) begin
            n_fail++;
            $display("FAIL first_start_done: done after %0d cycles, want 2", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        logic [CNT_W-1:0] n;
        for (int i = 0; i < 40; i++) begin
            d = WIDTH'($urandom_range(0, 15));
            n = CNT_W'($urandom_range(0, 7));
            run_seq("random", d, n, bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_shift();
        test_ignore_start();
        test_long_shift();
        test_clr();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_seq_ctrl
